sys_arr_result_drain: RTL and testbench

- Consumer side of the systolic array's completion interface.
- Waits for the array to raise comp_done, snapshots the ROWS x COLS single_float result matrix and the error flag, then streams the elements out in row-major order over a valid/ready port.
- Sits between sys_array and the downstream result sink (host bridge or next layer), replacing direct level-sampled reads of the result ports.

---
 rtl/dsp_sys_arr_pkg.sv | 23 ++
 rtl/sys_arr_result_drain.sv | 126 ++++++++++++
 tb/tb_sys_arr_result_drain.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dsp_sys_arr_pkg.sv
// Shared types for the systolic array datapath and its result drain.
// Holds the float element type, drain state encoding and a NaN helper.
package dsp_sys_arr_pkg;

    localparam int SF_W = 32;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } single_float;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } drain_state_t;

    function automatic logic is_nan(input single_float f);
        return (f.exponent == 8'hFF) && (f.mantissa != '0);
    endfunction

endpackage

// File: rtl/sys_arr_result_drain.sv
// Snapshots the array result matrix on completion and streams it
// out row-major over a valid/ready port, one element per beat.
module sys_arr_result_drain
    import dsp_sys_arr_pkg::*;
#(
    parameter int ROWS = 2,
    parameter int COLS = 2,
    parameter int DW   = 32,
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   comp_done,
    input  logic                   error,
    input  logic [ROWS*COLS*DW-1:0] res_flat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic [RW-1:0]          out_row,
    output logic [CW-1:0]          out_col,
    output logic                   out_last,
    output logic                   out_err,
    output logic                   out_nan,
    output logic                   busy,
    output logic                   drain_done,
    output logic                   overrun
);

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    drain_state_t  state;
    logic          comp_done_q;
    logic          err_q;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    single_float   buffer [ROWS][COLS];
    single_float   cur;
    logic          start;
    logic          at_last;

    assign start   = comp_done & ~comp_done_q;
    assign at_last = (row == ROW_LAST) && (col == COL_LAST);
    assign cur     = buffer[row][col];

    // Delayed copy of comp_done for rising-edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            comp_done_q <= 1'b0;
        end else begin
            comp_done_q <= comp_done;
        end
    end

    // Capture, row-major index walk and overrun tracking.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            err_q   <= 1'b0;
            overrun <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    buffer[r][c] <= '0;
                end
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        for (int r = 0; r < ROWS; r++) begin
                            for (int c = 0; c < COLS; c++) begin
                                buffer[r][c] <= single_float'(
                                    res_flat[(r*COLS+c)*DW +: DW]);
                            end
                        end
                        err_q <= error;
                        row   <= '0;
                        col   <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (start) begin
                        overrun <= 1'b1;
                    end
                    if (out_ready) begin
                        if (at_last) begin
                            state <= DONE;
                        end else if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        overrun <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Beat outputs decode from state and the frozen buffer.
    always_comb begin
        out_valid  = (state == STREAM);
        busy       = (state != IDLE);
        drain_done = (state == DONE);
        out_data   = cur;
        out_row    = row;
        out_col    = col;
        out_last   = out_valid & at_last;
        out_err    = out_valid & err_q;
        out_nan    = out_valid & is_nan(cur);
    end

endmodule

// File: tb/tb_sys_arr_result_drain.sv
// Self-checking bench for the result drain: table vectors, hand-written
// corner sequences and random drains against a row-major model.
module tb_sys_arr_result_drain;

    logic         CLK;
    logic         RST;
    logic         comp_done;
    logic         error;
    logic [127:0] res_flat;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [0:0]   out_row;
    logic [0:0]   out_col;
    logic         out_last;
    logic         out_err;
    logic         out_nan;
    logic         busy;
    logic         drain_done;
    logic         overrun;

    int pass_n = 0;
    int tot_n  = 0;
    logic exp_ovr = 1'b0;

    sys_arr_result_drain #(.ROWS(2), .COLS(2), .DW(32)) dut (
        .CLK(CLK), .RST(RST), .comp_done(comp_done), .error(error),
        .res_flat(res_flat), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .out_col(out_col), .out_last(out_last), .out_err(out_err),
        .out_nan(out_nan), .busy(busy), .drain_done(drain_done),
        .overrun(overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0][31:0] m;
        logic             err;
        logic [3:0]       nan;
        int               mode;
    } vec_t;

    vec_t tbl[4];

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)",
                      name, act, exp, $time);
    endfunction

    function automatic logic model_nan(logic [31:0] x);
        int e;
        int f;
        e = (x / (1 << 23)) % 256;
        f = x % (1 << 23);
        return (e == 255) && (f != 0);
    endfunction

    task automatic do_drain(input logic [3:0][31:0] m, input logic e,
                            input logic [3:0] nmask, input int mode,
                            input bit corrupt, input bit retrig);
        int   idx = 0;
        int   cyc = 0;
        logic r;
        res_flat  = m;
        error     = e;
        comp_done = 1'b1;
        @(negedge CLK);
        if (corrupt) begin
            res_flat = '0;
            error    = ~e;
        end
        while (idx < 4 && cyc < 64) begin
            chk("beat",
                {out_valid, busy, drain_done, out_data, out_row,
                 out_col, out_last, out_err, out_nan},
                {1'b1, 1'b1, 1'b0, m[idx], idx[1], idx[0],
                 (idx == 3), e, nmask[idx]});
            if (retrig && idx == 0) comp_done = 1'b0;
            if (retrig && idx == 1) comp_done = 1'b1;
            case (mode)
                0: r = 1'b1;
                1: r = cyc[0];
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            @(negedge CLK);
            cyc++;
            if (r) idx++;
        end
        if (idx < 4) chk("drain_timeout", 64'(idx), 64'd4);
        chk("done_pulse", {out_valid, drain_done, busy}, 3'b011);
        out_ready = 1'b0;
        @(negedge CLK);
        chk("back_idle", {out_valid, drain_done, busy}, 3'b000);
        chk("overrun", overrun, exp_ovr);
    endtask

    logic [3:0][31:0] basic;
    logic [3:0][31:0] rm;
    logic [3:0]       rn;

    initial begin
        basic = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        tbl[0] = '{basic, 1'b0, 4'b0000, 0};
        tbl[1] = '{basic, 1'b0, 4'b0000, 1};
        tbl[2] = '{{32'h40800000, 32'h7FC00000, 32'h40000000,
                    32'h3F800000}, 1'b1, 4'b0100, 0};
        tbl[3] = '{{32'h7F800000, 32'hFF800001, 32'h00000000,
                    32'h7F800000}, 1'b0, 4'b0100, 1};

        RST = 1'b1; comp_done = 1'b0; error = 1'b0;
        res_flat = '0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("reset_out",
                {out_valid, busy, drain_done, overrun, out_err, out_nan},
                6'b0);
        end
        RST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("post_reset",
                {out_valid, busy, drain_done, overrun, out_err, out_nan},
                6'b0);
        end

        for (int t = 0; t < 4; t++) begin
            do_drain(tbl[t].m, tbl[t].err, tbl[t].nan, tbl[t].mode,
                     1'b0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                @(negedge CLK);
                chk("held_no_redrain", {out_valid, busy}, 2'b00);
            end
            comp_done = 1'b0;
            @(negedge CLK);
        end

        do_drain(basic, 1'b0, 4'b0000, 1, 1'b1, 1'b0);
        comp_done = 1'b0;
        @(negedge CLK);

        exp_ovr = 1'b1;
        do_drain(basic, 1'b0, 4'b0000, 0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("no_extra_drain", {out_valid, busy, overrun}, 3'b001);
        end
        comp_done = 1'b0;
        @(negedge CLK);
        do_drain(basic, 1'b1, 4'b0000, 0, 1'b0, 1'b0);
        comp_done = 1'b0;
        @(negedge CLK);

        res_flat  = basic;
        comp_done = 1'b1;
        out_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        chk("mid_beat3", {out_valid, out_row, out_col}, 3'b110);
        RST = 1'b1;
        #1;
        chk("async_rst",
            {out_valid, busy, drain_done, overrun, out_err}, 5'b0);
        comp_done = 1'b0;
        out_ready = 1'b0;
        exp_ovr   = 1'b0;
        @(negedge CLK);
        chk("rst_no_done", {drain_done, busy}, 2'b00);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_idle", {out_valid, busy, overrun}, 3'b000);
        do_drain(basic, 1'b0, 4'b0000, 0, 1'b0, 1'b0);
        comp_done = 1'b0;
        @(negedge CLK);

        for (int n = 0; n < 20; n++) begin
            for (int j = 0; j < 4; j++) begin
                rm[j] = $urandom;
                if ($urandom_range(0, 3) == 0)
                    rm[j][30:23] = 8'hFF;
                rn[j] = model_nan(rm[j]);
            end
            do_drain(rm, 1'($urandom_range(0, 1)), rn, 2, 1'b0, 1'b0);
            comp_done = 1'b0;
            @(negedge CLK);
        end

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

endmodule
